// File: rtl/hex_ascii_parser.sv
// Hex ASCII to binary word parser: accumulates up to WIDTH/4 hex digits (MSB first)
// and emits a right-aligned word on a terminator or when the word is full.
module hex_ascii_parser #(
    parameter int WIDTH    = 16,
    parameter bit LOWER_OK = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       char_in,
    input  logic             char_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             err,
    output logic             busy
);
    localparam int DIGITS = WIDTH / 4;
    localparam int CW     = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    // Returns {is_digit, nibble}; lowercase letters count only when LOWER_OK is set.
    function automatic logic [4:0] decode_char(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) begin
            return {1'b1, c[3:0]};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            return {1'b1, c[3:0] + 4'd9};
        end else if (LOWER_OK && c >= 8'h61 && c <= 8'h66) begin
            return {1'b1, c[3:0] + 4'd9};
        end else begin
            return {1'b0, 4'd0};
        end
    endfunction

    function automatic logic is_term(input logic [7:0] c);
        return (c == 8'h0D) || (c == 8'h0A) || (c == 8'h20);
    endfunction

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] acc_r, acc_next_s, acc_shift_s, emit_word_s, word_out_r;
    logic [CW-1:0]    cnt_r, cnt_next_s, cnt_inc_s;
    logic [4:0]       dec_s;
    logic [3:0]       nib_s;
    logic             digit_s, term_s, emit_s, err_s;
    logic             word_valid_r, err_r, busy_r;

    // Character classification and the token state machine.
    always_comb begin
        dec_s        = decode_char(char_in);
        digit_s      = dec_s[4];
        nib_s        = dec_s[3:0];
        term_s       = is_term(char_in);
        acc_shift_s  = acc_r << 3'd4;
        acc_shift_s[3:0] = nib_s;
        cnt_inc_s    = cnt_r + CNT_ONE;
        state_next_s = state_r;
        acc_next_s   = acc_r;
        cnt_next_s   = cnt_r;
        emit_s       = 1'b0;
        emit_word_s  = acc_r;
        err_s        = 1'b0;
        if (char_valid) begin
            case (state_r)
                IDLE, ACCUM: begin
                    if (digit_s) begin
                        if (cnt_inc_s == CNT_FULL) begin
                            emit_s       = 1'b1;
                            emit_word_s  = acc_shift_s;
                            acc_next_s   = '0;
                            cnt_next_s   = '0;
                            state_next_s = IDLE;
                        end else begin
                            acc_next_s   = acc_shift_s;
                            cnt_next_s   = cnt_inc_s;
                            state_next_s = ACCUM;
                        end
                    end else if (term_s) begin
                        // A terminator in IDLE is ignored; acc is already zero there.
                        emit_s       = (state_r == ACCUM);
                        acc_next_s   = '0;
                        cnt_next_s   = '0;
                        state_next_s = IDLE;
                    end else begin
                        err_s        = 1'b1;
                        acc_next_s   = '0;
                        cnt_next_s   = '0;
                        state_next_s = DISCARD;
                    end
                end
                DISCARD: begin
                    if (term_s) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DISCARD;
                    end
                end
                default: begin
                    acc_next_s   = '0;
                    cnt_next_s   = '0;
                    state_next_s = IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            acc_r        <= '0;
            cnt_r        <= '0;
            word_out_r   <= '0;
            word_valid_r <= 1'b0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            acc_r        <= acc_next_s;
            cnt_r        <= cnt_next_s;
            word_valid_r <= emit_s;
            err_r        <= err_s;
            busy_r       <= (state_next_s != IDLE);
            if (emit_s) begin
                word_out_r <= emit_word_s;
            end else begin
                word_out_r <= word_out_r;
            end
        end
    end

    assign word_out   = word_out_r;
    assign word_valid = word_valid_r;
    assign err        = err_r;
    assign busy       = busy_r;
endmodule

// File: tb/tb_hex_ascii_parser.sv
// Scoreboard bench: stimulus pushes expected pulses (kind, value, cycle); per-DUT
// monitors pop and compare whenever word_valid or err is seen.
module tb_hex_ascii_parser;
    localparam int K_NONE = 0;
    localparam int K_WORD = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int          kind;
        logic [15:0] val;
        longint      cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  char_in;
    logic        cv0, cv1;
    logic [15:0] wo0, wo1;
    logic        wv0, wv1, er0, er1, bz0, bz1;

    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;
    exp_t   q0[$];
    exp_t   q1[$];

    hex_ascii_parser #(.WIDTH(16), .LOWER_OK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(cv0),
        .word_out(wo0), .word_valid(wv0), .err(er0), .busy(bz0)
    );

    hex_ascii_parser #(.WIDTH(16), .LOWER_OK(1'b0)) dut_uc (
        .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(cv1),
        .word_out(wo1), .word_valid(wv1), .err(er1), .busy(bz1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send(input int d, input logic [7:0] c, input int kind, input logic [15:0] val);
        exp_t e;
        @(negedge clk);
        char_in = c;
        cv0 = (d == 0);
        cv1 = (d == 1);
        if (kind != K_NONE) begin
            e.kind = kind;
            e.val  = val;
            e.cyc  = cyc + 1;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cv0 = 1'b0;
            cv1 = 1'b0;
            char_in = 8'h00;
        end
    endtask

    // Monitor for the LOWER_OK=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (wv0 && er0) begin
                tests++; fails++;
                $display("FAIL dut0_excl: word_valid and err both high at cycle %0d", cyc);
            end
            while (q0.size() > 0 && q0[0].cyc < cyc) begin
                e = q0.pop_front();
                tests++; fails++;
                $display("FAIL dut0_missed: no pulse, expected kind %0d val %h at cycle %0d", e.kind, e.val, e.cyc);
            end
            if (wv0 || er0) begin
                tests++;
                if (q0.size() == 0) begin
                    fails++;
                    $display("FAIL dut0_unexpected: wv=%0b err=%0b word=%h at cycle %0d, expected no pulse", wv0, er0, wo0, cyc);
                end else begin
                    e = q0.pop_front();
                    if (e.kind != (wv0 ? K_WORD : K_ERR) || e.cyc != cyc || (wv0 && wo0 !== e.val)) begin
                        fails++;
                        $display("FAIL dut0_pulse: got kind %0d word %h cycle %0d, expected kind %0d word %h cycle %0d",
                                 wv0 ? K_WORD : K_ERR, wo0, cyc, e.kind, e.val, e.cyc);
                    end
                end
            end
        end
    end

    // Monitor for the LOWER_OK=0 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (wv1 && er1) begin
                tests++; fails++;
                $display("FAIL dut1_excl: word_valid and err both high at cycle %0d", cyc);
            end
            while (q1.size() > 0 && q1[0].cyc < cyc) begin
                e = q1.pop_front();
                tests++; fails++;
                $display("FAIL dut1_missed: no pulse, expected kind %0d val %h at cycle %0d", e.kind, e.val, e.cyc);
            end
            if (wv1 || er1) begin
                tests++;
                if (q1.size() == 0) begin
                    fails++;
                    $display("FAIL dut1_unexpected: wv=%0b err=%0b word=%h at cycle %0d, expected no pulse", wv1, er1, wo1, cyc);
                end else begin
                    e = q1.pop_front();
                    if (e.kind != (wv1 ? K_WORD : K_ERR) || e.cyc != cyc || (wv1 && wo1 !== e.val)) begin
                        fails++;
                        $display("FAIL dut1_pulse: got kind %0d word %h cycle %0d, expected kind %0d word %h cycle %0d",
                                 wv1 ? K_WORD : K_ERR, wo1, cyc, e.kind, e.val, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; cv0 = 1'b0; cv1 = 1'b0; char_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs0", {14'd0, wv0, er0, bz0, wo0}, 32'd0);
        check("reset_outputs1", {14'd0, wv1, er1, bz1, wo1}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: "12Af" full word emits on last digit, CR afterwards ignored
        send(0, "1", K_NONE, 16'h0);
        send(0, "2", K_NONE, 16'h0);
        check("busy_mid_token", {31'd0, bz0}, 32'd1);
        send(0, "A", K_NONE, 16'h0);
        send(0, "f", K_WORD, 16'h12AF);
        send(0, 8'h0D, K_NONE, 16'h0);
        idle(3);
        check("busy_after_t1", {31'd0, bz0}, 32'd0);
        check("word_held_t1", {16'd0, wo0}, 32'h12AF);

        // 2: short token zero-extended, space in IDLE ignored
        send(0, "3", K_NONE, 16'h0);
        send(0, "C", K_NONE, 16'h0);
        send(0, 8'h0A, K_WORD, 16'h003C);
        send(0, 8'h20, K_NONE, 16'h0);
        idle(3);
        check("word_held_t2", {16'd0, wo0}, 32'h003C);

        // 3: bad char discards rest of token
        send(0, "1", K_NONE, 16'h0);
        send(0, "G", K_ERR, 16'h0);
        send(0, "5", K_NONE, 16'h0);
        send(0, "9", K_NONE, 16'h0);
        check("busy_discard", {31'd0, bz0}, 32'd1);
        send(0, 8'h0D, K_NONE, 16'h0);
        send(0, "7", K_NONE, 16'h0);
        send(0, 8'h0D, K_WORD, 16'h0007);
        idle(3);

        // 4: lowercase rejected on LOWER_OK=0, accepted on LOWER_OK=1
        send(1, "a", K_ERR, 16'h0);
        send(1, 8'h0D, K_NONE, 16'h0);
        send(1, "B", K_NONE, 16'h0);
        send(1, 8'h0D, K_WORD, 16'h000B);
        send(0, "a", K_NONE, 16'h0);
        send(0, 8'h0D, K_WORD, 16'h000A);
        idle(3);
        check("word_held_uc", {16'd0, wo1}, 32'h000B);

        // 5: reset mid-token drops partial word
        send(0, "4", K_NONE, 16'h0);
        send(0, "5", K_NONE, 16'h0);
        idle(1);
        rst_n = 1'b0;
        #1;
        check("async_reset_word", {16'd0, wo0}, 32'd0);
        check("async_reset_busy", {31'd0, bz0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'h0D, K_NONE, 16'h0);
        idle(3);
        check("word_after_reset", {16'd0, wo0}, 32'd0);
        send(0, "8", K_NONE, 16'h0);
        send(0, 8'h0D, K_WORD, 16'h0008);
        idle(3);

        // 6: back-to-back full words, pulses 4 cycles apart
        send(0, "F", K_NONE, 16'h0);
        send(0, "F", K_NONE, 16'h0);
        send(0, "F", K_NONE, 16'h0);
        send(0, "F", K_WORD, 16'hFFFF);
        send(0, "0", K_NONE, 16'h0);
        send(0, "0", K_NONE, 16'h0);
        send(0, "0", K_NONE, 16'h0);
        send(0, "1", K_WORD, 16'h0001);
        send(0, 8'h20, K_NONE, 16'h0);
        idle(3);

        // Boundaries: chars adjacent to digit ranges, err right after word
        send(0, "5", K_NONE, 16'h0);
        send(0, 8'h0D, K_WORD, 16'h0005);
        send(0, 8'h40, K_ERR, 16'h0);
        send(0, "G", K_NONE, 16'h0);
        send(0, 8'h3A, K_NONE, 16'h0);
        send(0, 8'h20, K_NONE, 16'h0);
        send(0, 8'h3A, K_ERR, 16'h0);
        send(0, 8'h0A, K_NONE, 16'h0);
        send(0, "9", K_NONE, 16'h0);
        send(0, 8'h67, K_ERR, 16'h0);
        send(0, 8'h0D, K_NONE, 16'h0);
        send(0, "0", K_NONE, 16'h0);
        send(0, 8'h0D, K_WORD, 16'h0000);
        idle(5);

        check("queue0_drained", q0.size(), 32'd0);
        check("queue1_drained", q1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
